// File: rtl/stream_packet_arbiter_if.sv
// Handshake bundle between the stream crossbar and its packet arbiter bank.
// The crossbar side uses the master modport; the arbiter bank uses slave.
interface stream_packet_arbiter_if #(
  parameter int S_DATA_COUNT = 2,
  parameter int M_DATA_COUNT = 3
);
  localparam int T_ID___WIDTH = $clog2(S_DATA_COUNT);
  localparam int T_DEST_WIDTH = $clog2(M_DATA_COUNT);

  logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0] s_dest_i;
  logic [S_DATA_COUNT-1:0]                   s_last_i;
  logic [S_DATA_COUNT-1:0]                   s_valid_i;
  logic [M_DATA_COUNT-1:0]                   m_ready_i;
  logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0] grant_o;
  logic [M_DATA_COUNT-1:0]                   arbiter_ready_o;

  modport master (
    output s_dest_i, s_last_i, s_valid_i, m_ready_i,
    input  grant_o, arbiter_ready_o
  );

  modport slave (
    input  s_dest_i, s_last_i, s_valid_i, m_ready_i,
    output grant_o, arbiter_ready_o
  );
endinterface

// File: rtl/stream_packet_arbiter.sv
// Bank of packet-locked round-robin arbiters, one lane per master channel.
// A lane holds its grant from the arbitration edge until the last beat is accepted.
module stream_packet_arbiter_lane #(
  parameter int S_DATA_COUNT = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [S_DATA_COUNT-1:0]         req,
  input  logic [S_DATA_COUNT-1:0]         s_valid,
  input  logic [S_DATA_COUNT-1:0]         s_last,
  input  logic                            m_ready,
  output logic [$clog2(S_DATA_COUNT)-1:0] grant,
  output logic                            locked
);
  localparam int IW = $clog2(S_DATA_COUNT);
  // One spare bit so ptr + offset (at most 2*S-1) never overflows before the wrap.
  localparam logic [IW:0] S_CNT = (IW+1)'(S_DATA_COUNT);

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW:0]   idx_w;
  logic [IW-1:0] win;
  logic          found;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= IW'(S_DATA_COUNT-1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    found   = 1'b0;
    win     = '0;
    idx_w   = '0;
    // Scan ptr+1 .. ptr+S with an explicit wrap; works for any source count.
    for (int k = 1; k <= S_DATA_COUNT; k++) begin
      idx_w = {1'b0, ptr_q} + (IW+1)'(k);
      if (idx_w >= S_CNT) idx_w = idx_w - S_CNT;
      if (!found && req[idx_w[IW-1:0]]) begin
        found = 1'b1;
        win   = idx_w[IW-1:0];
      end
    end
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d = win;
          state_d = S_LOCKED;
        end
      end
      S_LOCKED: begin
        if (s_valid[grant_q] && s_last[grant_q] && m_ready) begin
          ptr_d   = grant_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign grant  = grant_q;
  assign locked = (state_q == S_LOCKED);
endmodule

module stream_packet_arbiter #(
  parameter int T_DATA_WIDTH = 8,
  parameter int S_DATA_COUNT = 2,
  parameter int M_DATA_COUNT = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  stream_packet_arbiter_if.slave bus
);
  localparam int T_ID___WIDTH = $clog2(S_DATA_COUNT);
  localparam int T_DEST_WIDTH = $clog2(M_DATA_COUNT);

  // Lanes elaborate only for a legal parameter set; data width is carried for compatibility.
  if (S_DATA_COUNT >= 2 && M_DATA_COUNT >= 2 && T_DATA_WIDTH >= 1 && T_ID___WIDTH >= 1)
  begin : g_bank
    for (genvar m = 0; m < M_DATA_COUNT; m++) begin : g_lane
      logic [S_DATA_COUNT-1:0] req;

      for (genvar j = 0; j < S_DATA_COUNT; j++) begin : g_req
        assign req[j] = bus.s_valid_i[j] && (bus.s_dest_i[j] == T_DEST_WIDTH'(m));
      end

      stream_packet_arbiter_lane #(.S_DATA_COUNT(S_DATA_COUNT)) u_lane (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req     (req),
        .s_valid (bus.s_valid_i),
        .s_last  (bus.s_last_i),
        .m_ready (bus.m_ready_i[m]),
        .grant   (bus.grant_o[m]),
        .locked  (bus.arbiter_ready_o[m])
      );
    end
  end
endmodule

// File: tb/tb_stream_packet_arbiter.sv
// Bench for stream_packet_arbiter with S=3, M=3 (non-power-of-two source count).
module tb_stream_packet_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stream_packet_arbiter_if #(.S_DATA_COUNT(3), .M_DATA_COUNT(3)) bus ();

  stream_packet_arbiter #(.T_DATA_WIDTH(8), .S_DATA_COUNT(3), .M_DATA_COUNT(3)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    string      nm;
    logic [2:0] v;
    logic [2:0] l;
    logic [5:0] d;
    logic [2:0] mr;
    logic [2:0] er;
    logic [5:0] eg;
  } vec_t;

  typedef struct {
    string      nm;
    logic [2:0] rdy;
    logic [5:0] gnt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(logic [2:0] v, logic [2:0] l, logic [5:0] d, logic [2:0] mr);
    bus.s_valid_i = v;
    bus.s_last_i  = l;
    bus.s_dest_i  = d;
    bus.m_ready_i = mr;
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({e.nm, " rdy"}, 32'(bus.arbiter_ready_o), 32'(e.rdy));
    chk({e.nm, " gnt"}, 32'(bus.grant_o), 32'(e.gnt));
  endtask

  // Drive one cycle of inputs, expect the registered state after the next edge.
  task automatic step(string nm, logic [2:0] v, logic [2:0] l, logic [5:0] d,
                      logic [2:0] mr, logic [2:0] er, logic [5:0] eg);
    drive(v, l, d, mr);
    sb.push_back('{nm, er, eg});
    @(posedge clk);
    #1;
    pop_check();
  endtask

  function automatic void add(string nm, logic [2:0] v, logic [2:0] l, logic [5:0] d,
                              logic [2:0] mr, logic [2:0] er, logic [5:0] eg);
    vecs.push_back('{nm, v, l, d, mr, er, eg});
  endfunction

  initial begin
    logic [1:0] g;

    // single packet: src1 -> dest2, three beats
    add("single_lock", 3'b010, 3'b000, {2'd0, 2'd2, 2'd0}, 3'b111, 3'b100, {2'd1, 2'd0, 2'd0});
    add("single_b1",   3'b010, 3'b000, {2'd0, 2'd2, 2'd0}, 3'b111, 3'b100, {2'd1, 2'd0, 2'd0});
    add("single_b2",   3'b010, 3'b000, {2'd0, 2'd2, 2'd0}, 3'b111, 3'b100, {2'd1, 2'd0, 2'd0});
    add("single_eop",  3'b010, 3'b010, {2'd0, 2'd2, 2'd0}, 3'b111, 3'b000, {2'd1, 2'd0, 2'd0});
    add("single_idle", 3'b000, 3'b000, {2'd0, 2'd2, 2'd0}, 3'b111, 3'b000, {2'd1, 2'd0, 2'd0});
    // contention: all three sources to dest0, 2-beat packets -> grants 0,1,2,0,1
    for (int p = 0; p < 5; p++) begin
      g = 2'(p % 3);
      add($sformatf("cont%0d_lock", p), 3'b111, 3'b000, 6'd0, 3'b111, 3'b001, {2'd1, 2'd0, g});
      add($sformatf("cont%0d_b1", p),   3'b111, 3'b000, 6'd0, 3'b111, 3'b001, {2'd1, 2'd0, g});
      add($sformatf("cont%0d_eop", p),  3'b111, 3'b111, 6'd0, 3'b111, 3'b000, {2'd1, 2'd0, g});
    end

    drive(3'b000, 3'b000, 6'd0, 3'b111);
    #2;
    chk("reset_async rdy", 32'(bus.arbiter_ready_o), 32'd0);
    chk("reset_async gnt", 32'(bus.grant_o), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    chk("reset_held rdy", 32'(bus.arbiter_ready_o), 32'd0);
    chk("reset_held gnt", 32'(bus.grant_o), 32'd0);
    rst = 1'b0;

    foreach (vecs[i])
      step(vecs[i].nm, vecs[i].v, vecs[i].l, vecs[i].d, vecs[i].mr, vecs[i].er, vecs[i].eg);

    // backpressure on the last beat: lane0 ptr=1, so src0 wins after wrapping
    step("bp_lock", 3'b001, 3'b000, 6'd0, 3'b111, 3'b001, {2'd1, 2'd0, 2'd0});
    for (int i = 0; i < 5; i++)
      step($sformatf("bp_hold%0d", i), 3'b001, 3'b001, 6'd0, 3'b110, 3'b001, {2'd1, 2'd0, 2'd0});
    step("bp_accept", 3'b001, 3'b001, 6'd0, 3'b111, 3'b000, {2'd1, 2'd0, 2'd0});

    // parallel lock on dest0/dest1, src2 aimed at nonexistent dest3
    step("par_lock", 3'b111, 3'b000, {2'd3, 2'd1, 2'd0}, 3'b111, 3'b011, {2'd1, 2'd1, 2'd0});
    step("par_b1",   3'b111, 3'b000, {2'd3, 2'd1, 2'd0}, 3'b111, 3'b011, {2'd1, 2'd1, 2'd0});
    step("par_eop",  3'b111, 3'b011, {2'd3, 2'd1, 2'd0}, 3'b111, 3'b000, {2'd1, 2'd1, 2'd0});
    step("bad_dest", 3'b100, 3'b100, {2'd3, 2'd1, 2'd0}, 3'b111, 3'b000, {2'd1, 2'd1, 2'd0});

    // reset mid-packet: lane0 ptr=0 picks src1; after reset the search restarts at src0
    step("rm_lock", 3'b011, 3'b000, 6'd0, 3'b111, 3'b001, {2'd1, 2'd1, 2'd1});
    step("rm_b1",   3'b011, 3'b000, 6'd0, 3'b111, 3'b001, {2'd1, 2'd1, 2'd1});
    drive(3'b011, 3'b000, 6'd0, 3'b111);
    rst = 1'b1;
    #2;
    chk("rm_async rdy", 32'(bus.arbiter_ready_o), 32'd0);
    chk("rm_async gnt", 32'(bus.grant_o), 32'd0);
    rst = 1'b0;
    sb.push_back('{"rm_restart", 3'b001, 6'd0});
    @(posedge clk); #1;
    pop_check();
    step("rm_eop",  3'b011, 3'b001, 6'd0, 3'b111, 3'b000, 6'd0);
    step("rm_next", 3'b011, 3'b000, 6'd0, 3'b111, 3'b001, {2'd0, 2'd0, 2'd1});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete, limit 20000");
    $fatal(1);
  end
endmodule
